// File: rtl/isa_bus_arbiter_if.sv
// Card-side ISA bus bundle: requester handshake plus the shared bus pins.
// The arbiter connects through the master modport because it masters the
// ISA bus; requesters and the bus model use the slave modport.
interface isa_bus_arbiter_if #(
  parameter int NREQ = 4
) ();

  // Requester side
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_we;
  logic [16*NREQ-1:0]   req_addr;
  logic [16*NREQ-1:0]   req_wdata;
  logic [NREQ-1:0]      ack;
  logic [15:0]          rd_data;
  logic                 busy;

  // ISA bus side
  logic [15:0]          bus_address;
  logic [15:0]          bus_data_out;
  logic                 bus_data_dir;
  logic [15:0]          bus_data_in;
  logic                 bus_ior_n;
  logic                 bus_iow_n;

  modport master (
    input  req, req_we, req_addr, req_wdata, bus_data_in,
    output ack, rd_data, busy,
    output bus_address, bus_data_out, bus_data_dir, bus_ior_n, bus_iow_n
  );

  modport slave (
    output req, req_we, req_addr, req_wdata, bus_data_in,
    input  ack, rd_data, busy,
    input  bus_address, bus_data_out, bus_data_dir, bus_ior_n, bus_iow_n
  );

endinterface

// File: rtl/isa_bus_arbiter.sv
// Round-robin arbiter and ISA I/O cycle sequencer. Grants one requester at
// a time, latches its request fields, runs a setup/strobe/hold I/O cycle,
// captures read data and pulses a one-cycle acknowledge.
// The interface instance must be built with the same NREQ as this module.
module isa_bus_arbiter #(
  parameter int NREQ       = 4,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 8,
  parameter int HOLD_CYC   = 2
) (
  input  logic                sys_clock,
  input  logic                reset,
  isa_bus_arbiter_if.master   bus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [7:0]       r_cnt;
  logic [7:0]       w_cnt_next;
  logic             w_cnt_zero;

  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] r_gnt_idx;
  logic [IDX_W-1:0] w_gnt_idx;
  logic             w_gnt_vld;

  logic [15:0]      r_addr;
  logic [15:0]      r_wdata;
  logic             r_we;
  logic [15:0]      r_rd_data;
  logic [NREQ-1:0]  w_ack;

  assign w_cnt_zero = (r_cnt == 8'd0);

  // Pick the first active requester at or above the priority pointer, wrapping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default infers a latch.
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      int j;
      j = int'(r_ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (!w_gnt_vld && bus.req[j]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = IDX_W'(j);
      end
    end
  end

  // Next state and phase counter: each timed phase runs until the counter hits 0.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (w_gnt_vld) begin
          w_next_state = S_SETUP;
          w_cnt_next   = 8'(SETUP_CYC - 1);
        end
      end
      S_SETUP: begin
        if (w_cnt_zero) begin
          w_next_state = S_STROBE;
          w_cnt_next   = 8'(STROBE_CYC - 1);
        end else begin
          w_cnt_next   = r_cnt - 8'd1;
        end
      end
      S_STROBE: begin
        if (w_cnt_zero) begin
          w_next_state = S_HOLD;
          w_cnt_next   = 8'(HOLD_CYC - 1);
        end else begin
          w_cnt_next   = r_cnt - 8'd1;
        end
      end
      S_HOLD: begin
        if (w_cnt_zero) w_next_state = S_DONE;
        else            w_cnt_next   = r_cnt - 8'd1;
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // State register; reset discards any in-flight transaction.
  always_ff @(posedge sys_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // Latch the granted request at grant time and advance the priority pointer.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_ptr     <= '0;
      r_gnt_idx <= '0;
      r_addr    <= 16'h0000;
      r_wdata   <= 16'h0000;
      r_we      <= 1'b0;
    end else if (r_state == S_IDLE && w_gnt_vld) begin
      r_gnt_idx <= w_gnt_idx;
      r_addr    <= bus.req_addr[{w_gnt_idx, 4'b0000} +: 16];
      r_wdata   <= bus.req_wdata[{w_gnt_idx, 4'b0000} +: 16];
      r_we      <= bus.req_we[w_gnt_idx];
      r_ptr     <= (w_gnt_idx == IDX_W'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

  // Capture read data on the edge that ends the strobe.
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      r_rd_data <= 16'h0000;
    end else if (r_state == S_STROBE && w_cnt_zero && !r_we) begin
      r_rd_data <= bus.bus_data_in;
    end
  end

  // Bus and handshake outputs decoded from the registered state and latched fields.
  always_comb begin
    w_ack            = '0;
    bus.bus_address  = 16'h0000;
    bus.bus_data_out = 16'h0000;
    bus.bus_data_dir = 1'b0;
    bus.bus_ior_n    = 1'b1;
    bus.bus_iow_n    = 1'b1;
    if (r_state == S_SETUP || r_state == S_STROBE || r_state == S_HOLD) begin
      bus.bus_address  = r_addr;
      bus.bus_data_out = r_we ? r_wdata : 16'h0000;
      bus.bus_data_dir = r_we;
    end
    if (r_state == S_STROBE) begin
      bus.bus_iow_n = !r_we;
      bus.bus_ior_n = r_we;
    end
    if (r_state == S_DONE) w_ack[r_gnt_idx] = 1'b1;
  end

  assign bus.ack     = w_ack;
  assign bus.rd_data = r_rd_data;
  assign bus.busy    = (r_state != S_IDLE);

endmodule

// File: doc/isa_bus_arbiter.md
# isa_bus_arbiter

Round-robin arbiter and ISA I/O cycle sequencer sharing the single card-side ISA bus interface among NREQ requesters, such as the port scanner, DSP command writer and mixer configurator. It grants one requester at a time and latches that requester's address, direction and write data. It then runs one timed I/O cycle (setup, strobe, hold), captures read data and returns a one-cycle acknowledge. This replaces direct multi-driver connection of sub-blocks to the bus address/data pins.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8).
- SETUP_CYC, 2: sys_clock cycles of address/data valid before strobe (1..255).
- STROBE_CYC, 8: sys_clock cycles strobe held low (1..255).
- HOLD_CYC, 2: sys_clock cycles address/data held after strobe release (1..255).

Ports:
- sys_clock  in  1  system clock; all logic on rising edge.
- reset  in  1  reset, synchronous, active-high.
- req  in  NREQ  per-requester request level.
- req_we  in  NREQ  per-requester direction: 1 = write, 0 = read.
- req_addr  in  16*NREQ  per-requester I/O address; requester i at bits [16i+15:16i].
- req_wdata  in  16*NREQ  per-requester write data, same packing.
- ack  out  NREQ  one-cycle completion pulse, one-hot.
- rd_data  out  16  data captured by the last read; valid while ack is high, held until the next read.
- busy  out  1  high in any state other than IDLE.
- bus_address  out  16  ISA address.
- bus_data_out  out  16  ISA write data.
- bus_data_dir  out  1  1 = card drives data bus, 0 = input.
- bus_data_in  in  16  ISA read data.
- bus_ior_n  out  1  I/O read strobe, active-low.
- bus_iow_n  out  1  I/O write strobe, active-low.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE. An 8-bit down-counter times SETUP, STROBE and HOLD.
- IDLE:
  - If any req bit is high, grant the first requester at or after priority pointer `ptr`, searching upward modulo NREQ.
  - Latch that requester's index, addr, we and wdata.
  - Load the counter with SETUP_CYC-1 and go to SETUP.
  - `ptr` becomes granted index + 1, modulo NREQ.
- SETUP:
  - bus_address = latched address.
  - bus_data_dir = latched we; bus_data_out = wdata if write, else 0.
  - Both strobes high.
  - On counter = 0, load STROBE_CYC-1 and go to STROBE.
- STROBE:
  - Same bus values as SETUP.
  - bus_iow_n low if write, bus_ior_n low if read.
  - On counter = 0: for a read, capture bus_data_in into rd_data on that edge; load HOLD_CYC-1 and go to HOLD.
- HOLD:
  - Strobes high; address, data and dir held.
  - On counter = 0, go to DONE.
- DONE:
  - ack[granted] = 1 for exactly this cycle.
  - Bus outputs return to idle values.
  - Next state is IDLE.
- Requester contract:
  - Hold req, we, addr and wdata stable until ack is seen.
  - Deassert req at the edge ending the ack cycle (registered `if (ack) req <= 0`).
  - IDLE re-arbitrates on the cycle after DONE.
- Request fields are latched at grant. A requester dropping req or changing fields mid-transaction does not affect the cycle; the transaction completes and ack is still pulsed.
- Only one strobe is ever low, and never outside STROBE.
- Idle / reset values:
  - bus_address = 0x0000, bus_data_out = 0x0000, bus_data_dir = 0.
  - bus_ior_n = 1, bus_iow_n = 1.
  - ack = 0, busy = 0.
  - rd_data = 0x0000 at reset, held otherwise.
  - ptr = 0, state = IDLE.

## Timing
- req high sampled in IDLE at edge k: SETUP begins at k, and the bus address is valid in the cycle following edge k.
- Strobe low for exactly STROBE_CYC cycles, starting SETUP_CYC cycles after the address becomes valid.
- ack high in cycle k+SETUP_CYC+STROBE_CYC+HOLD_CYC, i.e. k+12 at defaults.
- Minimum spacing between back-to-back grants is SETUP_CYC+STROBE_CYC+HOLD_CYC+2 cycles (14 at defaults).
- Simultaneous requests: serviced in round-robin order from `ptr`. No requester waits more than NREQ-1 transactions.
- Reset mid-operation (any state): at the next edge, state = IDLE, strobes high, all outputs at idle values, no ack issued, ptr = 0. The in-flight transaction is discarded.
- reset has priority over all other inputs.

## Test plan
- Single write:
  - Stimulus: req[0], we=1, addr 0x0226, wdata 0x0001.
  - Required: bus_address=0x0226 and bus_data_dir=1 for 12 cycles; bus_iow_n low for exactly 8 cycles starting 2 cycles after the address; bus_ior_n never low; ack=0001 once at grant+12.
- Single read:
  - Stimulus: req[1], we=0, addr 0x022A, bus_data_in=0x00AA during strobe.
  - Required: bus_ior_n low for 8 cycles; bus_data_dir=0; rd_data=0x00AA when ack=0010 pulses.
- Simultaneous requests:
  - Stimulus: req[0] and req[2] raised in the same cycle from reset.
  - Required: requester 0 granted first, then 2 after 14 cycles; each gets one ack; no strobe overlap.
- Round-robin fairness:
  - Stimulus: all four req held continuously, re-raised after each ack.
  - Required: grant order 0,1,2,3,0,1,…; ack never multi-hot.
- Reset mid-strobe:
  - Stimulus: reset asserted in the 4th STROBE cycle of a write.
  - Required: next cycle bus_iow_n=1, bus_address=0, busy=0, no ack; the next request gets the full setup/strobe/hold.
- Request dropped:
  - Stimulus: req[3] deasserted during SETUP.
  - Required: the cycle still completes with the latched address, and ack[3] still pulses.
